// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath: internal 33-bit format
// layout, IEEE-754 constants and the sequential operator state encoding.
package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int MANT_W    = 24;
    localparam int BIAS      = 127;
    localparam int WORD_W    = 1 + EXP_W + MANT_W;
    localparam int IEEE_W    = 32;

    // Internal-format field offsets: [32] sign, [31:24] exponent, [23:0] mantissa
    localparam int SIGN_BIT  = WORD_W - 1;
    localparam int EXP_HI    = WORD_W - 2;
    localparam int EXP_LO    = MANT_W;
    localparam int MANT_HI   = MANT_W - 1;
    localparam int MANT_LO   = 0;

    // Gaps of this size or more shift the smaller mantissa out entirely
    localparam int ALIGN_MAX = MANT_W + 1;

    localparam logic [EXP_W-1:0]  EXP_MAX      = '1;
    localparam logic [IEEE_W-1:0] IEEE_POS_INF = 32'h7F80_0000;
    localparam logic [IEEE_W-1:0] IEEE_NEG_INF = 32'hFF80_0000;
    localparam logic [IEEE_W-1:0] IEEE_ZERO    = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        OP,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp_pack_ieee.sv
// Combinational repack of the internal format into IEEE-754 single precision.
// A value without its hidden bit is either infinity (max exponent) or zero.
module fp_pack_ieee
    import fp_pkg::*;
(
    input  logic [WORD_W-1:0] val,
    output logic [IEEE_W-1:0] ieee
);

    logic             sgn;
    logic [EXP_W-1:0] ex;
    logic             hid;

    always_comb begin
        sgn = val[SIGN_BIT];
        ex  = val[EXP_HI:EXP_LO];
        hid = val[MANT_HI];
        if (!hid && (ex == EXP_MAX)) begin
            ieee = sgn ? IEEE_NEG_INF : IEEE_POS_INF;
        end else if (!hid) begin
            ieee      = IEEE_ZERO;
            ieee[IEEE_W-1] = sgn;
        end else begin
            ieee = {sgn, ex, val[MANT_HI-1:MANT_LO]};
        end
    end

endmodule

// File: rtl/fp_resta_seq.sv
// Sequential a - b on the internal float format: bit-serial alignment, one
// add/subtract cycle, then bit-serial normalization with truncation.
module fp_resta_seq
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] out,
    output logic [IEEE_W-1:0] nums_o,
    output logic              zero,
    output logic              underflow,
    output logic              overflow,
    output state_t            dbg_state
);

    // Handshake: start is taken only when the FSM is IDLE and done is low;
    // a and b are sampled on that edge. busy covers the whole operation
    // including the done cycle; done is a one-cycle pulse and out/flags hold.
    state_t state_q, state_d;

    logic               accept;
    logic               a_zero, b_zero, a_ge, swap, clamp;
    logic [WORD_W-1:0]  bn, xw, yw;
    logic [EXP_W:0]     diff;

    logic               rs, eff_sub;
    logic [EXP_W-1:0]   xe, e;
    logic [MANT_W-1:0]  xm, ym;
    logic [4:0]         dcnt;
    logic [MANT_W:0]    r;
    logic [WORD_W-1:0]  res;
    logic               res_z, res_u, res_o;
    logic               norm_end;

    assign accept    = (state_q == IDLE) && start && !done;
    assign busy      = (state_q != IDLE) || done;
    assign dbg_state = state_q;

    // Operand ordering: X has the larger magnitude, a zero operand is always Y
    always_comb begin
        bn           = b;
        bn[SIGN_BIT] = ~b[SIGN_BIT];
        a_zero       = (a[MANT_HI:MANT_LO] == '0);
        b_zero       = (b[MANT_HI:MANT_LO] == '0);
        a_ge         = (a[EXP_HI:MANT_LO] >= b[EXP_HI:MANT_LO]);
        swap         = b_zero ? 1'b0 : (a_zero ? 1'b1 : !a_ge);
        xw           = swap ? bn : a;
        yw           = swap ? a : bn;
        diff         = {1'b0, xw[EXP_HI:EXP_LO]} - {1'b0, yw[EXP_HI:EXP_LO]};
        clamp        = diff[EXP_W] || (diff >= (EXP_W+1)'(ALIGN_MAX));
    end

    always_comb begin
        if (r == '0) begin
            norm_end = 1'b1;
        end else if (r[MANT_W]) begin
            norm_end = (e == EXP_MAX);
        end else if (!r[MANT_W-1]) begin
            norm_end = (e == 8'd1);
        end else begin
            norm_end = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ALIGN;
            ALIGN:   if (dcnt == '0) state_d = OP;
            OP:      state_d = NORM;
            NORM:    if (norm_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs        <= 1'b0;
            eff_sub   <= 1'b0;
            xe        <= '0;
            xm        <= '0;
            ym        <= '0;
            dcnt      <= '0;
            r         <= '0;
            e         <= '0;
            res       <= '0;
            res_z     <= 1'b0;
            res_u     <= 1'b0;
            res_o     <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rs      <= xw[SIGN_BIT];
                        eff_sub <= xw[SIGN_BIT] ^ yw[SIGN_BIT];
                        xe      <= xw[EXP_HI:EXP_LO];
                        xm      <= xw[MANT_HI:MANT_LO];
                        ym      <= clamp ? '0 : yw[MANT_HI:MANT_LO];
                        dcnt    <= clamp ? '0 : diff[4:0];
                    end
                end
                ALIGN: begin
                    if (dcnt != '0) begin
                        ym   <= ym >> 1;
                        dcnt <= dcnt - 5'd1;
                    end
                end
                OP: begin
                    r <= eff_sub ? ({1'b0, xm} - {1'b0, ym}) : ({1'b0, xm} + {1'b0, ym});
                    e <= xe;
                end
                NORM: begin
                    if (r == '0) begin
                        res   <= '0;
                        res_z <= 1'b1;
                        res_u <= 1'b0;
                        res_o <= 1'b0;
                    end else if (r[MANT_W]) begin
                        if (e == EXP_MAX) begin
                            res   <= {rs, EXP_MAX, {MANT_W{1'b0}}};
                            res_z <= 1'b0;
                            res_u <= 1'b0;
                            res_o <= 1'b1;
                        end else begin
                            r <= r >> 1;
                            e <= e + 8'd1;
                        end
                    end else if (!r[MANT_W-1]) begin
                        if (e == 8'd1) begin
                            res   <= '0;
                            res_z <= 1'b1;
                            res_u <= 1'b1;
                            res_o <= 1'b0;
                        end else begin
                            r <= r << 1;
                            e <= e - 8'd1;
                        end
                    end else begin
                        res   <= {rs, e, r[MANT_HI:MANT_LO]};
                        res_z <= 1'b0;
                        res_u <= 1'b0;
                        res_o <= 1'b0;
                    end
                end
                DONE: begin
                    out       <= res;
                    zero      <= res_z;
                    underflow <= res_u;
                    overflow  <= res_o;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    fp_pack_ieee u_pack (
        .val  (out),
        .ieee (nums_o)
    );

endmodule

// File: tb/tb_fp_resta_seq.sv
// Self-checking bench for fp_resta_seq: directed corner cases plus random
// operands compared against an integer-arithmetic reference model.
module tb_fp_resta_seq;
    import fp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [32:0] a, b;
    logic        busy, done, zero, underflow, overflow;
    logic [32:0] out;
    logic [31:0] nums_o;
    state_t      dbg_state;

    int tests = 0;
    int fails = 0;

    fp_resta_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .nums_o    (nums_o),
        .zero      (zero),
        .underflow (underflow),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a - b from the arithmetic rules using plain integers
    function automatic void ref_model(input logic [32:0] ai, input logic [32:0] bi,
                                      output logic [32:0] ro, output logic [31:0] rn,
                                      output logic rz, output logic ru, output logic rv,
                                      output int lat);
        int   ae, am, be, bm, xe, xm, ye, ym, d, s, e, k;
        logic as_, bs, xs, ys, swap, fin;
        as_ = ai[32]; ae = int'(ai[31:24]); am = int'(ai[23:0]);
        bs = ~bi[32]; be = int'(bi[31:24]); bm = int'(bi[23:0]);
        if (bm == 0) swap = 1'b0;
        else if (am == 0) swap = 1'b1;
        else swap = (be > ae) || ((be == ae) && (bm > am));
        if (swap) begin xs = bs; xe = be; xm = bm; ys = as_; ye = ae; ym = am; end
        else begin xs = as_; xe = ae; xm = am; ys = bs; ye = be; ym = bm; end
        d = xe - ye;
        if (d < 0 || d > 24) begin ym = 0; d = 0; end
        else ym = ym >> d;
        s = (xs == ys) ? xm + ym : xm - ym;
        e = xe; k = 0; rz = 1'b0; ru = 1'b0; rv = 1'b0; ro = '0; fin = 1'b0;
        for (int it = 0; it < 64 && !fin; it++) begin
            if (s == 0) begin
                rz = 1'b1; fin = 1'b1;
            end else if (s >= 32'h0100_0000) begin
                if (e == 255) begin rv = 1'b1; ro = {xs, 8'hFF, 24'h0}; fin = 1'b1; end
                else begin s = s / 2; e++; k++; end
            end else if (s < 32'h0080_0000) begin
                if (e == 1) begin rz = 1'b1; ru = 1'b1; fin = 1'b1; end
                else begin s = s * 2; e--; k++; end
            end else begin
                ro = {xs, 8'(e), 24'(s)}; fin = 1'b1;
            end
        end
        rn  = {ro[32], ro[31:24], ro[22:0]};
        lat = d + k + 4;
    endfunction

    // Drives one request from posedge+1 and returns cycles until done is seen
    task automatic run_op(input logic [32:0] av, input logic [32:0] bv, output int lat);
        bit timed_out;
        if (done) begin @(posedge clk); #1; end
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = {1'($urandom_range(0, 1)), $urandom()};
        b = {1'($urandom_range(0, 1)), $urandom()};
        chk("busy_rise", busy, 1);
        lat = 0; timed_out = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            else begin @(posedge clk); #1; end
            if (done) begin lat = i; timed_out = 1'b0; break; end
        end
        chk("timeout", timed_out, 0);
    endtask

    initial begin
        int          lat, elat, ndone;
        logic [32:0] ra, rb, eo, seen_out;
        logic [31:0] en;
        logic        ez, eu, ev;
        int          mode, ea, eb, off;

        rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_nums", nums_o, 0);
        chk("rst_flags", {busy, done, zero, underflow, overflow}, 0);
        chk("rst_state", dbg_state, IDLE);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // 2.0 - 1.0
        run_op({1'b0, 8'h80, 24'h800000}, {1'b0, 8'h7F, 24'h800000}, lat);
        chk("sub_out", out, {1'b0, 8'h7F, 24'h800000});
        chk("sub_nums", nums_o, 32'h3F80_0000);
        chk("sub_lat", lat, 6);
        chk("sub_busy_done_cycle", busy, 1);

        // 1.0 - 1.0
        run_op({1'b0, 8'h7F, 24'h800000}, {1'b0, 8'h7F, 24'h800000}, lat);
        chk("zero_flag", zero, 1);
        chk("zero_out", out, 0);
        chk("zero_nums", nums_o, 0);
        chk("zero_lat", lat, 4);

        // 1.0 - (-1.0)
        run_op({1'b0, 8'h7F, 24'h800000}, {1'b1, 8'h7F, 24'h800000}, lat);
        chk("carry_nums", nums_o, 32'h4000_0000);
        chk("carry_lat", lat, 5);

        // Exponent gap beyond the mantissa width
        run_op({1'b0, 8'h90, 24'h800000}, {1'b0, 8'h60, 24'hFFFFFF}, lat);
        chk("gap_out", out, {1'b0, 8'h90, 24'h800000});
        chk("gap_lat", lat, 4);

        run_op({1'b0, 8'hFF, 24'hC00000}, {1'b1, 8'hFF, 24'hC00000}, lat);
        chk("ovf_flag", overflow, 1);
        chk("ovf_nums", nums_o, 32'h7F80_0000);
        chk("ovf_zero", zero, 0);

        run_op({1'b0, 8'h01, 24'h800000}, {1'b0, 8'h01, 24'h400000}, lat);
        chk("unf_flags", {underflow, zero}, 2'b11);
        chk("unf_out", out, 0);

        // Start in the done cycle must not be accepted
        a = {1'b0, 8'h80, 24'h800000}; b = {1'b0, 8'h7F, 24'h800000}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_cycle_start_busy", busy, 0);
        chk("done_cycle_start_state", dbg_state, IDLE);

        // Start pulsed while busy is ignored
        a = {1'b0, 8'h80, 24'h800000}; b = {1'b0, 8'h7F, 24'h800000}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = {1'b0, 8'h85, 24'hA00000}; b = {1'b1, 8'h70, 24'h900000}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; seen_out = '0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin ndone++; seen_out = out; end
            @(posedge clk); #1;
        end
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_out", seen_out, {1'b0, 8'h7F, 24'h800000});

        // Reset asserted during a long normalization
        a = {1'b0, 8'h7F, 24'h800001}; b = {1'b0, 8'h7F, 24'h800000}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dbg_state == NORM) break;
            @(posedge clk); #1;
        end
        chk("reach_norm", dbg_state, NORM);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out", out, 0);
        chk("abort_nums", nums_o, 0);
        chk("abort_ctrl", {busy, done, zero, underflow, overflow}, 0);
        chk("abort_state", dbg_state, IDLE);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        ra = {1'b1, 8'h82, 24'hC80000}; rb = {1'b0, 8'h7C, 24'hF00000};
        ref_model(ra, rb, eo, en, ez, eu, ev, elat);
        run_op(ra, rb, lat);
        chk("fresh_out", out, eo);
        chk("fresh_nums", nums_o, en);
        chk("fresh_lat", lat, elat);

        // Random operands against the reference model
        for (int n = 0; n < 60; n++) begin
            mode = int'($urandom_range(0, 4));
            ea = int'($urandom_range(1, 254));
            ra = {1'($urandom_range(0, 1)), 8'(ea), 1'b1, 23'($urandom())};
            case (mode)
                0: begin
                    off = int'($urandom_range(0, 60)) - 30;
                    eb = ea + off;
                    if (eb < 1) eb = 1;
                    if (eb > 254) eb = 254;
                    rb = {1'($urandom_range(0, 1)), 8'(eb), 1'b1, 23'($urandom())};
                end
                1: rb = {ra[32], ra[31:24], ra[23:0] ^ 24'($urandom_range(1, 255))};
                2: begin
                    ra[31:24] = 8'($urandom_range(1, 3));
                    rb = {ra[32], ra[31:24], 1'b1, 23'($urandom())};
                end
                3: begin
                    ra[31:24] = 8'($urandom_range(253, 255));
                    rb = {~ra[32], 8'($urandom_range(253, 255)), 1'b1, 23'($urandom())};
                end
                default: begin
                    rb = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 24'h0};
                    if ($urandom_range(0, 1) == 1) begin
                        eo = ra; ra = rb; rb = eo;
                    end
                end
            endcase
            ref_model(ra, rb, eo, en, ez, eu, ev, elat);
            run_op(ra, rb, lat);
            chk("rnd_out", out, eo);
            chk("rnd_nums", nums_o, en);
            chk("rnd_flags", {zero, underflow, overflow}, {ez, eu, ev});
            chk("rnd_lat", lat, elat);
        end

        @(posedge clk); #1;
        chk("final_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
